bpred_update_queue: RTL
=======================

# bpred_update_queue

Buffers resolved control-flow outcomes from the execute stage and drives the branch predictor's update port one entry per cycle. Computes the mispredict flag, the BTB/bimodal write payload and the memory byte enable for each entry. Holds entries while the predictor is stalled so no update is lost. Sits between execute and the predictor; it is the sole source of the predictor's `execute_bpredictor_*` inputs.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  execute stage retires a control-flow instruction this cycle.
- ex_is_branch  in  1  instruction went through the predictor; entries with 0 are ignored.
- ex_pc4  in  32  PC+4 of the instruction.
- ex_actual_target  in  32  resolved target.
- ex_actual_dir  in  1  resolved direction: 1 = taken.
- ex_pred_dir  in  1  direction predicted at fetch.
- ex_pred_target  in  32  target used at fetch.
- ex_bimodal  in  12  `{index[9:0], counter[1:0]}` captured at fetch.
- ex_carry  in  9  predictor memory low bits captured at fetch.
- ex_ready  out  1  queue can accept this cycle; equals not full.
- pred_stall  in  1  predictor stall; blocks dequeue.
- upd_valid  out  1  head entry valid; drives the predictor's update input.
- upd_pc4, upd_target  out  32 each  head fields.
- upd_dir, upd_miss  out  1 each  head direction and mispredict flag.
- upd_bimodal  out  12  head bimodal field.
- upd_btb_data  out  30  equals `upd_target[31:2]`.
- upd_carry_data  out  9  head carry field.
- upd_byte_en  out  4  `4'b1111` if upd_dir is 1, else `4'b0001`.
- miss_count, update_count  out  32 each  statistics.
- overflow_count  out  16  rejected pushes; saturates at 16'hFFFF.

## Operation
- Push: `ex_valid & ex_is_branch & ex_ready`. At the clock edge, write one entry at the tail:
  - pc4, actual_target, actual_dir, bimodal, carry;
  - miss = `(actual_dir != pred_dir) | (actual_dir & pred_dir & (actual_target != pred_target))`.
- Pop: `upd_valid & ~pred_stall`. Advance the head at the clock edge.
- update_count increments by 1 on each pop. miss_count increments by 1 on each pop where upd_miss = 1. Both wrap modulo 2^32.
- Overflow: `ex_valid & ex_is_branch & ~ex_ready` drops the input and increments overflow_count (saturating).
- Storage: circular buffer with log2(DEPTH)-bit read/write pointers that wrap and a count of width log2(DEPTH)+1.
  - full = (count == DEPTH); empty = (count == 0).
- Simultaneous push and pop: count is unchanged, both pointers advance.
  - When full, a push is rejected even if a pop occurs the same cycle, because ex_ready depends on count only.
- When empty, upd_valid = 0. The upd_* data outputs hold the last head contents; consumers must ignore them.
- Reset: pointers, count and all three statistics clear to 0; ex_ready = 1; upd_valid = 0.
  - Entry storage need not clear.
  - A reset asserted mid-operation discards all pending entries and produces no pops that cycle.
  - The predictor runs its own table-clear sweep during reset, so upd_valid must stay 0 throughout.

## Timing
- Push-to-visible latency is 1 cycle. An entry pushed at edge N shows upd_valid = 1 in the cycle after N, with no combinational bypass from ex_* to upd_*.
- upd_* outputs are functions of registered state only (head entry plus count).
- ex_ready is a function of count only; it has no combinational path from pred_stall.
- With pred_stall held at 0, throughput is one entry per cycle and queue occupancy stays at most 1.
- While pred_stall = 1, the head and its upd_* outputs are held stable, and pushes continue until full.
- Statistic counters update at the same edge as the pop that causes them.

## Test plan
- Single not-taken push: pc4 = 0x104, actual_dir = 0, pred_dir = 0, bimodal = 0x0A5. Next cycle: upd_valid = 1, upd_miss = 0, upd_byte_en = 0001. Following cycle: upd_valid = 0, update_count = 1.
- Taken with wrong target: actual_dir = 1, pred_dir = 1, actual_target = 0x200, pred_target = 0x1F0. Response: upd_miss = 1, upd_btb_data = 0x80, upd_byte_en = 1111, miss_count = 1 after the pop.
- Hold pred_stall = 1 and push 5 entries with DEPTH = 4. Response: ex_ready falls after the 4th push, overflow_count = 1. Release the stall: 4 pops in order on consecutive cycles, pc4 values match push order.
- Full queue with push and pop in the same cycle: push rejected, count goes 4 → 3, overflow_count increments by 1.
- Pointer wrap: 10 entries streamed with pred_stall toggling every cycle. Response: output order and contents match input order across the pointer wrap.
- Reset asserted with 3 entries pending and pred_stall = 0. Response: upd_valid = 0 in the next cycle, all counters = 0, ex_ready = 1, no update_count increment.

Source files
------------

// File: rtl/bpred_update_queue.sv
// bpred_update_queue
// Buffers resolved control-flow outcomes from execute and presents them to the
// branch predictor's update port one entry per cycle, holding entries while
// the predictor stalls. Also derives the mispredict flag, the BTB/bimodal
// write payload and the predictor memory byte enable for the head entry.
module bpred_update_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc4,
    input  logic [31:0] ex_actual_target,
    input  logic        ex_actual_dir,
    input  logic        ex_pred_dir,
    input  logic [31:0] ex_pred_target,
    input  logic [11:0] ex_bimodal,
    input  logic [8:0]  ex_carry,
    output logic        ex_ready,
    input  logic        pred_stall,
    output logic        upd_valid,
    output logic [31:0] upd_pc4,
    output logic [31:0] upd_target,
    output logic        upd_dir,
    output logic        upd_miss,
    output logic [11:0] upd_bimodal,
    output logic [29:0] upd_btb_data,
    output logic [8:0]  upd_carry_data,
    output logic [3:0]  upd_byte_en,
    output logic [31:0] miss_count,
    output logic [31:0] update_count,
    output logic [15:0] overflow_count
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] target;
        logic        dir;
        logic        miss;
        logic [11:0] bimodal;
        logic [8:0]  carry;
    } entry_t;

    entry_t        entry_q [DEPTH];
    entry_t        entry_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   miss_count_q, miss_count_d;
    logic [31:0]   update_count_q, update_count_d;
    logic [15:0]   overflow_count_q, overflow_count_d;

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    logic   reject;
    logic   ex_miss;
    entry_t new_entry;
    entry_t head;

    // Occupancy flags and handshake qualifiers; ready depends on count only
    always_comb begin
        full      = (count_q == (AW+1)'(DEPTH));
        empty     = (count_q == '0);
        push      = ex_valid & ex_is_branch & ~full;
        reject    = ex_valid & ex_is_branch & full;
        pop       = ~empty & ~pred_stall;
        ex_miss   = (ex_actual_dir != ex_pred_dir)
                  | (ex_actual_dir & ex_pred_dir & (ex_actual_target != ex_pred_target));
        new_entry = '{pc4:     ex_pc4,
                      target:  ex_actual_target,
                      dir:     ex_actual_dir,
                      miss:    ex_miss,
                      bimodal: ex_bimodal,
                      carry:   ex_carry};
    end

    // Next-state for pointers, occupancy and statistics
    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        miss_count_d     = miss_count_q;
        update_count_d   = update_count_q;
        overflow_count_d = overflow_count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d       = rd_ptr_q + AW'(1);
            update_count_d = update_count_q + 32'd1;
            if (head.miss) begin
                miss_count_d = miss_count_q + 32'd1;
            end
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (reject && (overflow_count_q != 16'hFFFF)) begin
            overflow_count_d = overflow_count_q + 16'd1;
        end
    end

    // Next-state for entry storage: only the tail slot is written on a push
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (push) begin
            entry_d[wr_ptr_q] = new_entry;
        end
    end

    // Control state registers; reset discards pending entries and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            miss_count_q     <= '0;
            update_count_q   <= '0;
            overflow_count_q <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            miss_count_q     <= miss_count_d;
            update_count_q   <= update_count_d;
            overflow_count_q <= overflow_count_d;
        end
    end

    // Entry storage registers; contents are don't-care until written
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= entry_d[i];
        end
    end

    // Update port driven purely from the registered head entry and count
    always_comb begin
        head           = entry_q[rd_ptr_q];
        ex_ready       = ~full;
        upd_valid      = ~empty;
        upd_pc4        = head.pc4;
        upd_target     = head.target;
        upd_dir        = head.dir;
        upd_miss       = head.miss;
        upd_bimodal    = head.bimodal;
        upd_btb_data   = head.target[31:2];
        upd_carry_data = head.carry;
        upd_byte_en    = head.dir ? 4'b1111 : 4'b0001;
        miss_count     = miss_count_q;
        update_count   = update_count_q;
        overflow_count = overflow_count_q;
    end

endmodule
